// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the execute-stage multiply/divide unit:
// M-extension funct3 codes, the sequencer state type and iteration count,
// plus small decode helpers used when a request is accepted.
package riscv_pkg;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    localparam int MULDIV_STATE_T_WIDTH = 2;
    localparam int MULDIV_ITER          = 32;

    typedef enum logic [MULDIV_STATE_T_WIDTH-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    // rs1 is interpreted as signed for MULH, MULHSU, DIV and REM
    function automatic logic isSignedA(input logic [2:0] f3);
        return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
               (f3 == FUNCT3_DIV)  || (f3 == FUNCT3_REM);
    endfunction

    // rs2 is interpreted as signed for MULH, DIV and REM only
    function automatic logic isSignedB(input logic [2:0] f3);
        return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath for muldiv_seq. Holds the 2*XLEN accumulator
// and both operand registers. In multiply mode (mode_i = 0) each step does a
// conditional add of the multiplicand into the upper half followed by a right
// shift; in divide mode (mode_i = 1) each step performs one restoring
// shift/trial-subtract. The dividend lives in its own left-shifting register
// so the accumulator ({remainder, quotient}) can start cleared for both modes.
module muldiv_iter_core
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              mode_i,
    input  logic [XLEN-1:0]   opA_i,
    input  logic [XLEN-1:0]   opB_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opA_q, opA_d;
    logic [XLEN-1:0]   opB_q, opB_d;
    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     remShift;
    logic [XLEN:0]     trial;

    // One multiply or divide step per enabled cycle; load clears the accumulator
    always_comb begin
        acc_d    = acc_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (opB_q[0] ? {1'b0, opA_q} : '0);
        remShift = {acc_q[2*XLEN-1:XLEN], opA_q[XLEN-1]};
        trial    = remShift - {1'b0, opB_q};
        if (load_i) begin
            acc_d = '0;
            opA_d = opA_i;
            opB_d = opB_i;
        end else if (step_i) begin
            if (!mode_i) begin
                acc_d = {mulSum, acc_q[XLEN-1:1]};
                opB_d = opB_q >> 1;
            end else begin
                if (!trial[XLEN]) begin
                    acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {remShift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
                opA_d = opA_q << 1;
            end
        end
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            opA_q <= '0;
            opB_q <= '0;
        end else begin
            acc_q <= acc_d;
            opA_q <= opA_d;
            opB_q <= opB_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_seq.sv
// Sequenced RV32M multiply/divide unit. A small FSM (IDLE, CALC, FIX, DONE)
// drives muldiv_iter_core on operand magnitudes, then restores signs and
// selects the result word. Divide-by-zero and signed overflow resolve at
// accept. Optional build macro MULDIV_FAST_MUL_EN replaces the iterative
// multiply with a single-cycle 33x33 signed multiply registered at accept.
module muldiv_seq
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t     state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              negA_q, negA_d;
    logic              negB_q, negB_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              aNeg, bNeg;
    logic [XLEN-1:0]   magA, magB;
    logic              divZero, divOvf, specialDiv;
    logic [XLEN-1:0]   specialResult;
    logic              fastMul;
    logic [XLEN-1:0]   fastResult;
    logic              coreLoad, coreStep;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] prodFixed;
    logic [XLEN-1:0]   quotFixed, remFixed;
    logic [XLEN-1:0]   fixResult;

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (coreLoad),
        .step_i (coreStep),
        .mode_i (funct3_q[2]),
        .opA_i  (magA),
        .opB_i  (magB),
        .acc_o  (acc)
    );

    // Decode the incoming request: operand signs, magnitudes and the divide special cases
    always_comb begin
        aNeg       = isSignedA(funct3_i) & rs1_i[XLEN-1];
        bNeg       = isSignedB(funct3_i) & rs2_i[XLEN-1];
        magA       = aNeg ? (~rs1_i + 1'b1) : rs1_i;
        magB       = bNeg ? (~rs2_i + 1'b1) : rs2_i;
        divZero    = funct3_i[2] && (rs2_i == '0);
        divOvf     = ((funct3_i == FUNCT3_DIV) || (funct3_i == FUNCT3_REM)) &&
                     (rs1_i == INT_MIN) && (rs2_i == '1);
        specialDiv = divZero || divOvf;
        if (divZero) begin
            specialResult = funct3_i[1] ? rs1_i : '1;
        end else begin
            specialResult = funct3_i[1] ? '0 : INT_MIN;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fastA, fastB;
    logic signed [2*XLEN+1:0] fastProd;
    logic                     unusedFastBits;

    // Single-cycle signed multiply on sign- or zero-extended operands
    always_comb begin
        fastA          = {isSignedA(funct3_i) & rs1_i[XLEN-1], rs1_i};
        fastB          = {isSignedB(funct3_i) & rs2_i[XLEN-1], rs2_i};
        fastProd       = fastA * fastB;
        unusedFastBits = ^fastProd[2*XLEN+1:2*XLEN];
        fastMul        = !funct3_i[2];
        fastResult     = (funct3_i == FUNCT3_MUL) ? fastProd[XLEN-1:0] : fastProd[2*XLEN-1:XLEN];
    end
`else
    // Without the fast path every multiply goes through the iterative core
    always_comb begin
        fastMul    = 1'b0;
        fastResult = '0;
    end
`endif

    // Sign correction and word select applied in the FIX state
    always_comb begin
        prodFixed = (negA_q ^ negB_q) ? (~acc + 1'b1) : acc;
        quotFixed = (negA_q ^ negB_q) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        remFixed  = negA_q ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        case (funct3_q)
            FUNCT3_MUL:                fixResult = prodFixed[XLEN-1:0];
            FUNCT3_DIV, FUNCT3_DIVU:   fixResult = quotFixed;
            FUNCT3_REM, FUNCT3_REMU:   fixResult = remFixed;
            default:                   fixResult = prodFixed[2*XLEN-1:XLEN];
        endcase
    end

    // Next-state logic; kill overrides everything and discards any pending update
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        funct3_d = funct3_q;
        negA_d   = negA_q;
        negB_d   = negB_q;
        result_d = result_q;
        coreLoad = 1'b0;
        coreStep = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start_i) begin
                    funct3_d = funct3_i;
                    negA_d   = aNeg;
                    negB_d   = bNeg;
                    if (specialDiv || fastMul) begin
                        state_d  = DONE;
                        result_d = specialDiv ? specialResult : fastResult;
                    end else begin
                        coreLoad = 1'b1;
                        count_d  = '0;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                coreStep = 1'b1;
                count_d  = count_q + 1'b1;
                if (count_q == CW'(MULDIV_ITER - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fixResult;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (kill_i) begin
            state_d  = IDLE;
            count_d  = count_q;
            funct3_d = funct3_q;
            negA_d   = negA_q;
            negB_d   = negB_q;
            result_d = result_q;
            coreLoad = 1'b0;
            coreStep = 1'b0;
        end
    end

    // Control and result registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            funct3_q <= '0;
            negA_q   <= 1'b0;
            negB_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            funct3_q <= funct3_d;
            negA_q   <= negA_d;
            negB_q   <= negB_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == CALC) || (state_q == FIX);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule
